mmio_out_fifo: RTL

Memory-mapped output port that snoops the processor's RAM write bus and captures stores to a dedicated I/O address into a small FIFO, presenting them to an external consumer over a valid/ready handshake. Sits directly downstream of the memory block, in parallel with the RAM, on the same `mar`/`write`/`RI` signals. It also exposes a status word on a second address, which the processor datapath muxes onto its read bus.

---
 rtl/tiny_pkg.sv | 15 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/mmio_out_fifo.sv | 66 ++++++
 3 files changed

// File: rtl/tiny_pkg.sv
// tiny_pkg: shared status-bit positions and default I/O address derivation
// Status word layout: bit0 empty, bit1 full, bit2 overflow, count from bit3 up.
// The data and status ports sit just below the top of the address space.
package tiny_pkg;
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 3;
    function automatic logic [31:0] io_addr_of(input int w);
        return (32'd1 << w) - 32'd2;
    endfunction
    function automatic logic [31:0] stat_addr_of(input int w);
        return (32'd1 << w) - 32'd3;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with count, async active-low reset
// Ports:
//   clk, reset (active low)        clock and asynchronous reset
//   push, wdata                    enqueue request and its data
//   pop                            dequeue request
//   rdata                          head entry (show-ahead)
//   full, empty, count             occupancy status
// A push while full is taken only if a pop frees a slot in the same cycle.
// A pop while empty is ignored. Storage is not reset.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             push_ok, pop_ok;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= wdata;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop_ok);
            wr_ptr <= wr_ptr + AW'(push_ok);
            count  <= count + CW'(push_ok) - CW'(pop_ok);
        end
endmodule

// File: rtl/mmio_out_fifo.sv
// mmio_out_fifo: snoops RAM stores to IO_ADDR into a FIFO drained by valid/ready
// Ports:
//   clk, reset (active low)   clock and asynchronous reset
//   mar, write, RI            processor address, RAM write bus, write strobe
//   stat_sel, stat_rd         status read select and status word (combinational)
//   out_data, out_valid       head-of-queue word and its valid flag
//   out_ready                 consumer accepts the head this cycle
//   overflow                  sticky flag: a store was dropped while full
// A store to STAT_ADDR clears overflow; RAM writes are never inhibited here.
module mmio_out_fifo
    import tiny_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] IO_ADDR   = WIDTH'(io_addr_of(WIDTH)),
    parameter logic [WIDTH-1:0] STAT_ADDR = WIDTH'(stat_addr_of(WIDTH))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] mar,
    input  logic [WIDTH-1:0] write,
    input  logic             RI,
    output logic             stat_sel,
    output logic [WIDTH-1:0] stat_rd,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          push, pop, full, empty, stat_wr;
    logic [CW-1:0] count;

    assign stat_sel  = mar == STAT_ADDR;
    assign push      = RI & (mar == IO_ADDR);
    assign stat_wr   = RI & stat_sel;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (write),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // A store is lost only when full with no pop making room this cycle.
    always_ff @(posedge clk or negedge reset)
        if (!reset)                    overflow <= 1'b0;
        else if (stat_wr)              overflow <= 1'b0;
        else if (push & full & ~pop)   overflow <= 1'b1;

    always_comb begin
        stat_rd                     = '0;
        stat_rd[ST_EMPTY]           = empty;
        stat_rd[ST_FULL]            = full;
        stat_rd[ST_OVF]             = overflow;
        stat_rd[ST_CNT_LSB +: CW]   = count;
    end
endmodule
